bus_arbiter2: RTL and testbench

//  Two-port round-robin arbiter for the shared 32-bit memory/peripheral bus. It sits between
//  the CPU (port 0) and a second bus master such as a DMA/blitter (port 1) on one side, and the

---
 rtl/bus_arbiter2.sv | 170 +++++++++++++++++
 tb/tb_bus_arbiter2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2.sv
// Two-port round-robin arbiter for the shared 32-bit peripheral bus.
// Optional macro BUS_ARB_TIMEOUT_EN adds a WAIT-state timeout that forces an erroring ack.
module bus_arbiter2 #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_req0,
   input  logic        i_req1,
   input  logic        i_we0,
   input  logic        i_we1,
   input  logic [31:0] i_addr0,
   input  logic [31:0] i_addr1,
   input  logic [31:0] i_wdata0,
   input  logic [31:0] i_wdata1,
   output logic        o_ack0,
   output logic        o_ack1,
   output logic [31:0] o_rdata,
   output logic        o_err,
   output logic [1:0]  o_grant,
   output logic        o_busy,
   output logic        o_bus_stb,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   state_t state_r;
   logic   last_grant_r;
   logic   win_s;
   logic   any_req_s;

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range_invalid
      $error("bus_arbiter2: TIMEOUT_CYCLES must be 1..255");
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);
   logic [7:0] wait_cnt_r;
   logic       err_r;
   assign o_err = err_r;
`else
   assign o_err = 1'b0;
`endif

   assign any_req_s = i_req0 | i_req1;

   // Round-robin pick: a lone request wins; on a tie the port not granted last time wins.
   always_comb begin
      win_s = 1'b0;
      if (i_req0 && i_req1) begin
         win_s = ~last_grant_r;
      end else if (i_req1) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
         o_ack0       <= 1'b0;
         o_ack1       <= 1'b0;
         o_rdata      <= 32'd0;
         o_grant      <= 2'b00;
         o_busy       <= 1'b0;
         o_bus_stb    <= 1'b0;
         o_bus_we     <= 1'b0;
         o_bus_addr   <= 32'd0;
         o_bus_wdata  <= 32'd0;
`ifdef BUS_ARB_TIMEOUT_EN
         wait_cnt_r   <= 8'd0;
         err_r        <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  last_grant_r <= win_s;
                  o_grant      <= win_s ? 2'b10 : 2'b01;
                  o_bus_we     <= win_s ? i_we1 : i_we0;
                  o_bus_addr   <= win_s ? i_addr1 : i_addr0;
                  o_bus_wdata  <= win_s ? i_wdata1 : i_wdata0;
                  o_bus_stb    <= 1'b1;
                  o_busy       <= 1'b1;
                  state_r      <= ST_ISSUE;
               end else begin
                  state_r      <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               o_bus_stb <= 1'b0;
               if (i_bus_ready) begin
                  o_rdata <= i_bus_rdata;
                  o_ack0  <= o_grant[0];
                  o_ack1  <= o_grant[1];
`ifdef BUS_ARB_TIMEOUT_EN
                  err_r   <= 1'b0;
`endif
                  state_r <= ST_ACK;
               end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                  wait_cnt_r <= 8'd0;
`endif
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_bus_ready) begin
                  o_rdata <= i_bus_rdata;
                  o_ack0  <= o_grant[0];
                  o_ack1  <= o_grant[1];
`ifdef BUS_ARB_TIMEOUT_EN
                  err_r   <= 1'b0;
`endif
                  state_r <= ST_ACK;
               end
`ifdef BUS_ARB_TIMEOUT_EN
               // The cycle that would bring the count to the limit forces completion instead.
               else if ((wait_cnt_r + 8'd1) == TIMEOUT_C) begin
                  o_rdata <= 32'd0;
                  o_ack0  <= o_grant[0];
                  o_ack1  <= o_grant[1];
                  err_r   <= 1'b1;
                  state_r <= ST_ACK;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
                  state_r    <= ST_WAIT;
               end
`else
               else begin
                  state_r <= ST_WAIT;
               end
`endif
            end
            ST_ACK: begin
               o_ack0  <= 1'b0;
               o_ack1  <= 1'b0;
               o_grant <= 2'b00;
               o_busy  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
               err_r   <= 1'b0;
`endif
               state_r <= ST_IDLE;
            end
            default: begin
               o_ack0    <= 1'b0;
               o_ack1    <= 1'b0;
               o_grant   <= 2'b00;
               o_busy    <= 1'b0;
               o_bus_stb <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the arbitration and completion rules.
module tb_bus_arbiter2;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int T_CFG = 8;
   localparam bit TO_EN = 1'b1;
`else
   localparam int T_CFG = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic [1:0]  req_v;
   logic [1:0]  we_v;
   logic [31:0] addr_v [2];
   logic [31:0] wdata_v [2];
   logic [31:0] i_bus_rdata;
   logic        i_bus_ready;
   logic        o_ack0, o_ack1, o_err, o_busy, o_bus_stb, o_bus_we;
   logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
   logic [1:0]  o_grant;

   int checks = 0;
   int errors = 0;
   bit last_m;

   bus_arbiter2 #(.TIMEOUT_CYCLES(T_CFG)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_req0(req_v[0]), .i_req1(req_v[1]),
      .i_we0(we_v[0]), .i_we1(we_v[1]),
      .i_addr0(addr_v[0]), .i_addr1(addr_v[1]),
      .i_wdata0(wdata_v[0]), .i_wdata1(wdata_v[1]),
      .o_ack0(o_ack0), .o_ack1(o_ack1),
      .o_rdata(o_rdata), .o_err(o_err), .o_grant(o_grant), .o_busy(o_busy),
      .o_bus_stb(o_bus_stb), .o_bus_we(o_bus_we),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
      .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: lone requester wins, a tie goes to the port that did not win last.
   function automatic int pick(input logic [1:0] r, input bit last);
      if (r == 2'b11) return last ? 0 : 1;
      else if (r[1]) return 1;
      else return 0;
   endfunction

   task automatic new_req(input int p);
      we_v[p]    = 1'($urandom_range(0, 1));
      addr_v[p]  = $urandom;
      wdata_v[p] = $urandom;
      req_v[p]   = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stb"}, {31'd0, o_bus_stb}, 32'd0);
      chk({tag, "_grant"}, {30'd0, o_grant}, 32'd0);
      chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({tag, "_acks"}, {30'd0, o_ack1, o_ack0}, 32'd0);
      chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
      chk({tag, "_rdata"}, o_rdata, 32'd0);
      chk({tag, "_addr"}, o_bus_addr, 32'd0);
      chk({tag, "_wdata"}, o_bus_wdata, 32'd0);
      chk({tag, "_we"}, {31'd0, o_bus_we}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rstn = 1'b0;
      #1;
      chk_all_zero("rst");
      @(negedge i_clk);
      chk("rst_hold_acks", {30'd0, o_ack1, o_ack0}, 32'd0);
      i_rstn = 1'b1;
      last_m = 1'b1;
   endtask

   // One transaction, entered just after an IDLE-cycle negedge with at least one req pending.
   // d: 0 = ready during ISSUE, k>0 = ready in the k-th WAIT cycle.
   task automatic txn(input int d, input logic [31:0] rd,
                      input logic [1:0] hold_mask, input logic [1:0] raise_mask);
      int          w, ack_at;
      bit          to;
      logic [1:0]  eg;
      logic [31:0] ea, ewd, erd;
      logic        ewe;
      w      = pick(req_v, last_m);
      last_m = w[0];
      eg     = (w == 1) ? 2'b10 : 2'b01;
      ea     = addr_v[w];
      ewd    = wdata_v[w];
      ewe    = we_v[w];
      to     = TO_EN && (d > T_CFG);
      ack_at = to ? T_CFG + 1 : d + 1;
      erd    = to ? 32'd0 : rd;
      @(negedge i_clk);
      chk("issue_stb", {31'd0, o_bus_stb}, 32'd1);
      chk("issue_grant", {30'd0, o_grant}, {30'd0, eg});
      chk("issue_addr", o_bus_addr, ea);
      chk("issue_wdata", o_bus_wdata, ewd);
      chk("issue_we", {31'd0, o_bus_we}, {31'd0, ewe});
      chk("issue_busy", {31'd0, o_busy}, 32'd1);
      i_bus_rdata = rd;
      i_bus_ready = (d == 0);
      for (int c = 1; c <= ack_at; c++) begin
         @(negedge i_clk);
         chk("hold_stb", {31'd0, o_bus_stb}, 32'd0);
         chk("hold_grant", {30'd0, o_grant}, {30'd0, eg});
         chk("hold_bus", o_bus_addr ^ o_bus_wdata ^ {31'd0, o_bus_we},
             ea ^ ewd ^ {31'd0, ewe});
         chk("hold_busy", {31'd0, o_busy}, 32'd1);
         if (c < ack_at) begin
            chk("early_ack", {30'd0, o_ack1, o_ack0}, 32'd0);
            i_bus_ready = (c == d);
            if (c == 1) begin
               if (raise_mask[0] && !req_v[0]) new_req(0);
               if (raise_mask[1] && !req_v[1]) new_req(1);
            end
         end else begin
            chk("ack", {30'd0, o_ack1, o_ack0}, {30'd0, eg});
            chk("ack_rdata", o_rdata, erd);
            chk("ack_err", {31'd0, o_err}, {31'd0, to});
            i_bus_ready = 1'($urandom_range(0, 1));
            if (hold_mask[w]) new_req(w);
            else req_v[w] = 1'b0;
         end
      end
      @(negedge i_clk);
      chk("idle_state", {28'd0, o_busy, o_bus_stb, o_grant}, 32'd0);
      chk("idle_acks", {29'd0, o_err, o_ack1, o_ack0}, 32'd0);
      chk("idle_rdata_hold", o_rdata, erd);
      chk("idle_addr_hold", o_bus_addr, ea);
      i_bus_ready = 1'($urandom_range(0, 1));
   endtask

   initial begin
      i_rstn      = 1'b0;
      req_v       = 2'b00;
      we_v        = 2'b00;
      addr_v[0]   = 32'd0;
      addr_v[1]   = 32'd0;
      wdata_v[0]  = 32'd0;
      wdata_v[1]  = 32'd0;
      i_bus_rdata = 32'd0;
      i_bus_ready = 1'b0;
      last_m      = 1'b1;
      do_reset();

      // Read with ready during ISSUE: minimum latency
      we_v[0] = 1'b0; addr_v[0] = 32'h0000_1234; wdata_v[0] = 32'd0; req_v[0] = 1'b1;
      txn(0, 32'h0000_005A, 2'b00, 2'b00);

      // Write completing after 6 WAIT cycles
      we_v[1] = 1'b1; addr_v[1] = 32'h4000_0010; wdata_v[1] = 32'h0000_00A5; req_v[1] = 1'b1;
      txn(6, 32'h1357_9BDF, 2'b00, 2'b00);

      // Tie from reset: both held, order must alternate starting at port 0
      do_reset();
      new_req(0);
      new_req(1);
      txn(2, $urandom, 2'b11, 2'b00);
      txn(0, $urandom, 2'b11, 2'b00);
      txn(3, $urandom, 2'b11, 2'b00);
      txn(1, $urandom, 2'b00, 2'b00);
      txn(1, $urandom, 2'b00, 2'b00);

      // Starvation: port 0 keeps requesting, port 1 arrives during its WAIT
      new_req(0);
      txn(1, $urandom, 2'b01, 2'b00);
      txn(3, $urandom, 2'b01, 2'b10);
      txn(2, $urandom, 2'b00, 2'b00);
      txn(0, $urandom, 2'b00, 2'b00);

`ifdef BUS_ARB_TIMEOUT_EN
      // Ready never arrives: forced completion, then a normal transaction
      new_req(0);
      txn(T_CFG + 20, 32'hDEAD_BEEF, 2'b00, 2'b00);
      new_req(0);
      txn(1, 32'h0000_0042, 2'b00, 2'b00);
`endif

      // Reset in WAIT: immediate clear, no ack, pending req re-granted after release
      new_req(0);
      @(negedge i_clk);
      chk("pre_rst_stb", {31'd0, o_bus_stb}, 32'd1);
      i_bus_ready = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rstn = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      @(negedge i_clk);
      chk("mid_rst_noack", {30'd0, o_ack1, o_ack0}, 32'd0);
      i_rstn = 1'b1;
      last_m = 1'b1;
      txn(0, 32'h0000_0077, 2'b00, 2'b00);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         if (!req_v[0] && ($urandom_range(0, 1) == 1)) new_req(0);
         if (!req_v[1] && ($urandom_range(0, 1) == 1)) new_req(1);
         if (req_v == 2'b00) new_req(int'($urandom_range(0, 1)));
         txn(int'($urandom_range(0, TO_EN ? 11 : 6)), $urandom,
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
